// File: rtl/uart_frame_sched_if.sv
// Bundle of the scheduler's handshake, UART, engine and RAM signals.
// master = the scheduler, slave = the surrounding cores, RAM and bench.
interface uart_frame_sched_if #(
    parameter int ADDR_W = 15
);
    logic              en;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic              proc_done;
    logic [ADDR_W-1:0] proc_addr;
    logic [7:0]        proc_wdata;
    logic              proc_we;
    logic              tx_busy;
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              proc_start;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              rx_ovf;
    logic              led_rx_n;
    logic              led_tx_n;

    modport master (
        input  en, rx_dv, rx_byte, proc_done, proc_addr, proc_wdata, proc_we,
               tx_busy, mem_rdata,
        output mem_addr, mem_wdata, mem_we, proc_start, tx_start, tx_byte,
               rx_ovf, led_rx_n, led_tx_n
    );

    modport slave (
        output en, rx_dv, rx_byte, proc_done, proc_addr, proc_wdata, proc_we,
               tx_busy, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, proc_start, tx_start, tx_byte,
               rx_ovf, led_rx_n, led_tx_n
    );
endinterface

// File: rtl/uart_frame_sched.sv
// Frame sequencer owning the single-port buffer: RX fill, engine pass, TX read-back.
// RX write lands one cycle after rx_dv; TX paced by tx_busy; en low aborts to IDLE.
module uart_frame_sched #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_frame_sched_if.master bus
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE, RX_FILL, PROC, TX_ADDR, TX_LAT, TX_WAIT, TX_HOLD, DONE
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic              mem_we_r;
    logic              proc_start_r;
    logic              tx_start_r;
    logic [7:0]        tx_byte_r;
    logic              rx_ovf_r;
    logic              led_rx_r;
    logic              led_tx_r;
    logic              ovf_set;

    // A strobe in RX_FILL only counts as overflow once the frame is already full.
    assign ovf_set = bus.rx_dv && (state != RX_FILL || (bus.en && wr_cnt == FULL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_we_r     <= 1'b0;
            proc_start_r <= 1'b0;
            tx_start_r   <= 1'b0;
            tx_byte_r    <= '0;
            rx_ovf_r     <= 1'b0;
            led_rx_r     <= 1'b1;
            led_tx_r     <= 1'b1;
        end else begin
            mem_we_r     <= 1'b0;
            proc_start_r <= 1'b0;
            tx_start_r   <= 1'b0;
            if (!bus.en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= RX_FILL;
                        wr_cnt   <= '0;
                        rd_cnt   <= '0;
                        rx_ovf_r <= 1'b0;
                        led_rx_r <= 1'b1;
                        led_tx_r <= 1'b1;
                    end
                    RX_FILL: begin
                        // Leave only after the last write has been on the bus.
                        if (wr_cnt == FULL) begin
                            state        <= PROC;
                            proc_start_r <= 1'b1;
                        end else if (bus.rx_dv) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= wr_cnt[ADDR_W-1:0];
                            mem_wdata_r <= bus.rx_byte;
                            wr_cnt      <= wr_cnt + ONE;
                            if (wr_cnt == FULL - ONE) led_rx_r <= 1'b0;
                        end
                    end
                    PROC: begin
                        if (bus.proc_done) begin
                            state      <= TX_ADDR;
                            mem_addr_r <= rd_cnt[ADDR_W-1:0];
                        end
                    end
                    TX_ADDR: state <= TX_LAT;
                    TX_LAT:  state <= TX_WAIT;
                    TX_WAIT: begin
                        tx_byte_r <= bus.mem_rdata;
                        if (!bus.tx_busy) begin
                            tx_start_r <= 1'b1;
                            rd_cnt     <= rd_cnt + ONE;
                            state      <= TX_HOLD;
                        end
                    end
                    TX_HOLD: begin
                        // tx_busy only rises the cycle after tx_start, so skip that cycle.
                        if (!tx_start_r && !bus.tx_busy) begin
                            if (rd_cnt == FULL) begin
                                state    <= DONE;
                                led_tx_r <= 1'b0;
                            end else begin
                                state      <= TX_ADDR;
                                mem_addr_r <= rd_cnt[ADDR_W-1:0];
                            end
                        end
                    end
                    DONE:    state <= DONE;
                    default: state <= IDLE;
                endcase
            end
            if (ovf_set) rx_ovf_r <= 1'b1;
        end
    end

    // Engine owns the port combinationally in PROC; strobes are squashed in the abort cycle.
    assign bus.mem_addr   = (state == PROC) ? bus.proc_addr  : mem_addr_r;
    assign bus.mem_wdata  = (state == PROC) ? bus.proc_wdata : mem_wdata_r;
    assign bus.mem_we     = ((state == PROC) ? bus.proc_we : mem_we_r) & bus.en;
    assign bus.proc_start = proc_start_r & bus.en;
    assign bus.tx_start   = tx_start_r & bus.en;
    assign bus.tx_byte    = tx_byte_r;
    assign bus.rx_ovf     = rx_ovf_r;
    assign bus.led_rx_n   = led_rx_r;
    assign bus.led_tx_n   = led_tx_r;
endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench: 16-byte frame instance end to end, plus a 32768-byte fill boundary instance.
module tb_uart_frame_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_sched_if #(.ADDR_W(4))  b4 ();
    uart_frame_sched_if #(.ADDR_W(15)) b15 ();

    uart_frame_sched #(.ADDR_W(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4.master));
    uart_frame_sched #(.ADDR_W(15)) u15 (.clk(clk), .rst_n(rst_n), .bus(b15.master));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model, TX busy model and bus monitors for the small instance
    logic [7:0] ram [16];
    int         cyc = 0;
    int         busy_cnt;
    int         waddr[$];
    int         wdat[$];
    int         wcyc[$];
    int         pcnt = 0;
    int         pcyc = -1;
    int         txq[$];
    int         txbad = 0;
    logic [7:0] last_tx = 8'h00;
    int         w15 = 0;

    always @(posedge clk) begin
        if (b4.mem_we) begin
            ram[b4.mem_addr] <= b4.mem_wdata;
            waddr.push_back(int'(b4.mem_addr));
            wdat.push_back(int'(b4.mem_wdata));
            wcyc.push_back(cyc);
        end
        b4.mem_rdata <= ram[b4.mem_addr];
        if (b4.proc_start) begin
            pcnt++;
            pcyc = cyc;
        end
        if (b4.tx_start) begin
            txq.push_back(int'(b4.tx_byte));
            last_tx = b4.tx_byte;
            if (b4.tx_busy) txbad++;
        end else if (b4.tx_busy && b4.tx_byte !== last_tx) begin
            txbad++;
        end
        if (b15.mem_we) w15++;
        cyc++;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b4.tx_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (b4.tx_start) begin
            b4.tx_busy <= 1'b1;
            busy_cnt   <= 10;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt   <= 0;
            b4.tx_busy <= 1'b0;
        end
    end

    task automatic strobe(input logic [7:0] b, input int gap);
        b4.rx_dv = 1'b1;
        b4.rx_byte = b;
        @(negedge clk);
        b4.rx_dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int n;
        int s;
        int base;
        b4.en = 0; b4.rx_dv = 0; b4.rx_byte = 0; b4.proc_done = 0;
        b4.proc_addr = 0; b4.proc_wdata = 0; b4.proc_we = 0;
        b15.en = 0; b15.rx_dv = 0; b15.rx_byte = 0; b15.proc_done = 0;
        b15.proc_addr = 0; b15.proc_wdata = 0; b15.proc_we = 0;
        b15.tx_busy = 0; b15.mem_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_we", b4.mem_we, 0);
        check("rst_mem_addr", b4.mem_addr, 0);
        check("rst_mem_wdata", b4.mem_wdata, 0);
        check("rst_strobes", {b4.proc_start, b4.tx_start}, 0);
        check("rst_tx_byte", b4.tx_byte, 0);
        check("rst_rx_ovf", b4.rx_ovf, 0);
        check("rst_leds", {b4.led_rx_n, b4.led_tx_n}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);

        // rx_dv while idle is dropped and flagged
        strobe(8'h55, 2);
        check("idle_no_write", waddr.size(), 0);
        check("idle_rx_ovf", b4.rx_ovf, 1);
        check("idle_leds", {b4.led_rx_n, b4.led_tx_n}, 2'b11);

        // fill 16 bytes spaced 3 cycles
        b4.en = 1'b1;
        @(negedge clk);
        check("fill_entry_ovf_clr", b4.rx_ovf, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("fill_led_before_last", b4.led_rx_n, 1);
            strobe(i[7:0], 2);
        end
        check("fill_write_count", waddr.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_addr%0d", i), waddr[i], i);
            check($sformatf("fill_data%0d", i), wdat[i], i);
        end
        check("fill_led_rx", b4.led_rx_n, 0);
        check("proc_start_count", pcnt, 1);
        check("proc_start_timing", pcyc, wcyc[15] + 1);

        // engine owns the port in PROC
        b4.proc_addr = 4'd7; b4.proc_wdata = 8'hA5; b4.proc_we = 1'b1;
        #1;
        check("proc_mux_addr", b4.mem_addr, 7);
        check("proc_mux_wdata", b4.mem_wdata, 8'hA5);
        check("proc_mux_we", b4.mem_we, 1);
        @(negedge clk);
        b4.proc_we = 1'b0; b4.proc_addr = 0; b4.proc_wdata = 0;
        strobe(8'h33, 1);
        check("proc_rx_dropped", waddr.size(), 17);
        check("proc_rx_ovf", b4.rx_ovf, 1);
        b4.proc_done = 1'b1;
        @(negedge clk);
        b4.proc_done = 1'b0;

        // read-back
        n = 0;
        while (b4.led_tx_n !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_done_in_time", n < 2000, 1);
        check("tx_start_count", txq.size(), 16);
        for (int i = 0; i < 16 && i < txq.size(); i++)
            check($sformatf("tx_byte%0d", i), txq[i], (i == 7) ? 8'hA5 : i);
        check("tx_busy_rules", txbad, 0);
        check("tx_no_mem_we", waddr.size(), 17);
        check("done_led_rx", b4.led_rx_n, 0);

        // abort from DONE keeps LEDs until next fill entry
        b4.en = 1'b0;
        @(negedge clk);
        check("abort_leds_held", {b4.led_rx_n, b4.led_tx_n}, 2'b00);
        b4.en = 1'b1;
        @(negedge clk);
        check("refill_leds", {b4.led_rx_n, b4.led_tx_n}, 2'b11);
        check("refill_ovf", b4.rx_ovf, 0);
        for (int i = 0; i < 5; i++) strobe(8'h20 + i[7:0], 2);
        check("abort_pre_writes", waddr.size(), 22);
        check("abort_pre_addr4", waddr[21], 4);
        b4.en = 1'b0;
        strobe(8'h99, 3);
        check("abort_no_write", waddr.size(), 22);
        check("abort_ovf_unchanged", b4.rx_ovf, 0);
        b4.en = 1'b1;
        @(negedge clk);
        strobe(8'h40, 2);
        check("restart_addr", waddr[waddr.size()-1], 0);
        check("restart_data", wdat[wdat.size()-1], 8'h40);

        // back-to-back strobes
        base = waddr.size();
        s = cyc;
        b4.rx_dv = 1'b1; b4.rx_byte = 8'h41;
        @(negedge clk);
        b4.rx_byte = 8'h42;
        @(negedge clk);
        b4.rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_count", waddr.size(), base + 2);
        check("b2b_addr0", waddr[base], 1);
        check("b2b_addr1", waddr[base+1], 2);
        check("b2b_data1", wdat[base+1], 8'h42);
        check("b2b_cyc0", wcyc[base], s + 1);
        check("b2b_cyc1", wcyc[base+1], s + 2);

        // 32768-byte frame boundary
        b15.en = 1'b1;
        @(negedge clk);
        b15.rx_dv = 1'b1;
        for (int i = 0; i < 32767; i++) begin
            b15.rx_byte = i[7:0];
            @(negedge clk);
        end
        b15.rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        check("big_writes_minus1", w15, 32767);
        check("big_led_not_yet", b15.led_rx_n, 1);
        b15.rx_dv = 1'b1;
        @(negedge clk);
        b15.rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        check("big_writes_full", w15, 32768);
        check("big_led_rx", b15.led_rx_n, 0);
        check("big_proc_start", b15.proc_start, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
